serial_feeder: RTL

Parallel-in, serial-out stage that sits directly upstream of the serial pattern detector and drives its `din` input. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock, in a configurable bit order. Words loaded back-to-back stream with no gap. Between words the line is held at 0, which returns the detector to its idle state.

---
 rtl/serial_pkg.sv | 25 ++
 rtl/serial_feeder.sv | 92 +++++++++
 2 files changed

// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial feeder / pattern detector slice.
package serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } feeder_state_t;

  localparam int MAX_W     = 64;
  localparam int MAX_IDX_W = 6;

  // Bit counter width for a WIDTH-bit word; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  function automatic logic first_bit(input logic [MAX_W-1:0] word,
                                     input int               width,
                                     input logic             msb_first);
    logic [MAX_IDX_W-1:0] idx;
    idx = MAX_IDX_W'(width - 1);
    return msb_first ? word[idx] : word[0];
  endfunction

endpackage

// File: rtl/serial_feeder.sv
// Parallel-in, serial-out stage feeding the pattern detector's din one bit per clock,
// with zero-bubble streaming of back-to-back words and a wrapping words-sent counter.
module serial_feeder
  import serial_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic [CNT_W-1:0] words_sent
);

  localparam int              BC_W = cnt_width(WIDTH);
  localparam logic [BC_W-1:0] LAST = BC_W'(WIDTH - 1);

  if ((WIDTH < 2) || (WIDTH > MAX_W)) begin : g_width_check
    $error("serial_feeder: WIDTH must be in 2..64");
  end

  feeder_state_t   state, state_next;
  logic [WIDTH-1:0] sr, sr_next;
  logic [BC_W-1:0]  bit_cnt, bit_cnt_next;
  logic             last_bit;
  logic             accept;

  always_comb begin
    last_bit   = (state == SHIFT) && (bit_cnt == LAST);
    load_ready = (state == IDLE) || last_bit;
    accept     = load_valid && load_ready;
  end

  always_comb begin
    state_next   = state;
    sr_next      = sr;
    bit_cnt_next = bit_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          sr_next      = load_data;
          bit_cnt_next = '0;
          state_next   = SHIFT;
        end
      end
      SHIFT: begin
        // Move the next payload bit into the output position.
        sr_next      = (MSB_FIRST != 0) ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
        bit_cnt_next = bit_cnt + 1'b1;
        if (last_bit) begin
          bit_cnt_next = '0;
          if (accept) begin
            sr_next = load_data;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sr         <= '0;
      bit_cnt    <= '0;
      words_sent <= '0;
    end else begin
      state   <= state_next;
      sr      <= sr_next;
      bit_cnt <= bit_cnt_next;
      if (last_bit) begin
        words_sent <= words_sent + 1'b1;
      end
    end
  end

  // Outputs decode registered state only, so dout moves just after a rising edge.
  always_comb begin
    dout_valid = (state == SHIFT);
    busy       = (state == SHIFT);
    dout       = (state == SHIFT) ? first_bit(MAX_W'(sr), WIDTH, logic'(MSB_FIRST != 0)) : 1'b0;
  end

endmodule
